uart_bus_master: RTL and testbench

Serial debug bridge acting as a bus initiator on the CPU-style memory bus (32-bit address/data, `mem_writeEnable`/`mem_readEnable` strobes, `mem_busy` completion). It consumes received bytes from a `simple_uart` receiver, decodes word read/write commands, performs one bus transaction per command, and returns results through the same UART's transmitter. It sits beside, or in place of, the CPU as the initiator in front of the existing peripheral decode, and is used for host-side memory poke/peek and program loading.

---
 rtl/uart_bus_master_if.sv | 26 ++
 rtl/uart_bus_master.sv | 141 ++++++++++++++
 tb/tb_uart_bus_master.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_bus_master_if.sv
// rtl/uart_bus_master_if.sv - UART byte stream and memory bus signals of the serial bus bridge
interface uart_bus_master_if;
  logic [7:0]  rxdata;
  logic        rxint;
  logic [7:0]  txdata;
  logic        txgo;
  logic        txready;
  logic [31:0] mem_addr;
  logic [31:0] mem_write;
  logic        mem_writeEnable;
  logic        mem_readEnable;
  logic [31:0] mem_read;
  logic        mem_busy;
  logic        active;
  logic        overrun;

  modport master (
    input  rxdata, rxint, txready, mem_read, mem_busy,
    output txdata, txgo, mem_addr, mem_write, mem_writeEnable, mem_readEnable, active, overrun
  );

  modport slave (
    output rxdata, rxint, txready, mem_read, mem_busy,
    input  txdata, txgo, mem_addr, mem_write, mem_writeEnable, mem_readEnable, active, overrun
  );
endinterface

// File: rtl/uart_bus_master.sv
// rtl/uart_bus_master.sv - UART command decoder acting as a 32-bit memory bus initiator
module uart_bus_master #(
  parameter int unsigned timeout_cycles = 100000
) (
  input  logic              clk,
  input  logic              reset,
  uart_bus_master_if.master bus
);
  localparam int unsigned GW = $clog2(timeout_cycles + 1);
  localparam logic [7:0] CMD_W  = 8'h57;
  localparam logic [7:0] CMD_R  = 8'h52;
  localparam logic [7:0] RESP_K = 8'h4B;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_BUSREQ, S_BUSWAIT, S_TXLOAD, S_TXWAIT
  } state_t;

  state_t          r_state, w_state_next;
  logic            r_is_write;
  logic [1:0]      r_cnt;
  logic [GW-1:0]   r_gap;
  logic            r_wait_done;
  logic [31:0]     r_resp;
  logic [7:0]      r_txdata;
  logic            r_txgo;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  logic            r_we;
  logic            r_re;
  logic            r_overrun;

  logic w_cmd_ok, w_last_byte, w_timeout, w_bus_done, w_tx_last, w_no_rx_state;

  assign w_cmd_ok      = (bus.rxdata == CMD_W) || (bus.rxdata == CMD_R);
  assign w_last_byte   = bus.rxint && (r_cnt == 2'd3);
  assign w_timeout     = !bus.rxint && (r_gap == GW'(timeout_cycles - 1));
  // The strobe cycle is the first BUSWAIT cycle; busy is not trusted until the strobe has dropped.
  assign w_bus_done    = !r_we && !r_re && !bus.mem_busy;
  assign w_tx_last     = r_is_write || (r_cnt == 2'd3);
  assign w_no_rx_state = (r_state == S_BUSREQ) || (r_state == S_BUSWAIT) ||
                         (r_state == S_TXLOAD) || (r_state == S_TXWAIT);

  assign bus.txdata          = r_txdata;
  assign bus.txgo            = r_txgo;
  assign bus.mem_addr        = r_addr;
  assign bus.mem_write       = r_wdata;
  assign bus.mem_writeEnable = r_we;
  assign bus.mem_readEnable  = r_re;
  assign bus.overrun         = r_overrun;
  assign bus.active          = (r_state != S_IDLE);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (bus.rxint && w_cmd_ok) w_state_next = S_ADDR;
      S_ADDR:    if (w_timeout) w_state_next = S_IDLE;
                 else if (w_last_byte) w_state_next = r_is_write ? S_DATA : S_BUSREQ;
      S_DATA:    if (w_timeout) w_state_next = S_IDLE;
                 else if (w_last_byte) w_state_next = S_BUSREQ;
      S_BUSREQ:  w_state_next = S_BUSWAIT;
      S_BUSWAIT: if (w_bus_done) w_state_next = S_TXLOAD;
      S_TXLOAD:  if (bus.txready) w_state_next = S_TXWAIT;
      S_TXWAIT:  if (r_wait_done) w_state_next = w_tx_last ? S_IDLE : S_TXLOAD;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // Datapath: byte assembly, gap counter, bus strobes, response shifting and transmit pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_is_write  <= 1'b0;
      r_cnt       <= 2'd0;
      r_gap       <= '0;
      r_wait_done <= 1'b0;
      r_resp      <= 32'h0;
      r_txdata    <= 8'h00;
      r_txgo      <= 1'b0;
      r_addr      <= 32'h0;
      r_wdata     <= 32'h0;
      r_we        <= 1'b0;
      r_re        <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_we      <= 1'b0;
      r_re      <= 1'b0;
      r_txgo    <= 1'b0;
      r_overrun <= bus.rxint && w_no_rx_state;
      case (r_state)
        S_IDLE: begin
          if (bus.rxint && w_cmd_ok) begin
            r_is_write <= (bus.rxdata == CMD_W);
            r_cnt      <= 2'd0;
            r_gap      <= '0;
          end
        end
        S_ADDR, S_DATA: begin
          if (bus.rxint) begin
            r_gap <= '0;
            r_cnt <= r_cnt + 2'd1;
            if (r_state == S_ADDR) r_addr  <= {r_addr[23:0], bus.rxdata};
            else                   r_wdata <= {r_wdata[23:0], bus.rxdata};
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        S_BUSREQ: begin
          r_we <= r_is_write;
          r_re <= !r_is_write;
        end
        S_BUSWAIT: begin
          if (w_bus_done) begin
            r_resp <= r_is_write ? {RESP_K, 24'h0} : bus.mem_read;
            r_cnt  <= 2'd0;
          end
        end
        S_TXLOAD: begin
          if (bus.txready) begin
            r_txdata    <= r_resp[31:24];
            r_txgo      <= 1'b1;
            r_wait_done <= 1'b0;
          end
        end
        S_TXWAIT: begin
          r_wait_done <= 1'b1;
          if (r_wait_done) begin
            r_resp <= {r_resp[23:0], 8'h00};
            r_cnt  <= r_cnt + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_bus_master.sv
// tb/tb_uart_bus_master.sv - randomized self-checking bench for uart_bus_master
module tb_uart_bus_master;
  localparam int TO = 50;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_bus_master_if bus();
  uart_bus_master #(.timeout_cycles(TO)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct packed { logic we; logic [31:0] addr; logic [31:0] data; } txn_t;

  int n_checks = 0;
  int n_pass = 0;
  txn_t q_txn[$];
  logic [7:0] q_tx[$];
  int n_ovr, n_viol, n_active;
  bit hold_busy = 1'b0;
  bit prev_go = 1'b0, prev_st = 1'b0, prev_rdy = 1'b1;
  logic [31:0] slave_mem [logic [31:0]];
  logic [31:0] model_mem [logic [31:0]];

  wire [76:0] outs = {bus.txdata, bus.txgo, bus.mem_addr, bus.mem_write, bus.mem_writeEnable,
                      bus.mem_readEnable, bus.active, bus.overrun};

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  // Expected response word of a command from the reference memory (write: 'K').
  function automatic logic [31:0] model_resp(input bit w, input logic [31:0] a);
    if (w) return 32'h0000_004B;
    return model_mem.exists(a) ? model_mem[a] : dflt(a);
  endfunction

  // Bus/UART observer, sampled mid-cycle.
  always @(negedge clk) begin
    txn_t t;
    logic st;
    st = bus.mem_writeEnable || bus.mem_readEnable;
    if (st) begin
      t.we = bus.mem_writeEnable; t.addr = bus.mem_addr; t.data = bus.mem_write;
      q_txn.push_back(t);
    end
    if (bus.mem_writeEnable && bus.mem_readEnable) n_viol++;
    if (bus.txgo) begin
      q_tx.push_back(bus.txdata);
      if (!prev_rdy) n_viol++;
    end
    if ((bus.txgo && prev_go) || (st && prev_st)) n_viol++;
    if (bus.overrun) n_ovr++;
    if (bus.active) n_active++;
    prev_go = bus.txgo; prev_st = st; prev_rdy = bus.txready;
  end

  // Memory responder with random latency.
  initial begin : responder
    logic w;
    logic [31:0] a, d;
    forever begin
      @(posedge clk); #1;
      if (reset && (bus.mem_writeEnable || bus.mem_readEnable)) begin
        w = bus.mem_writeEnable; a = bus.mem_addr; d = bus.mem_write;
        bus.mem_busy = 1'b1;
        repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
        while (hold_busy) begin @(posedge clk); #1; end
        if (w) slave_mem[a] = d;
        else   bus.mem_read = slave_mem.exists(a) ? slave_mem[a] : dflt(a);
        bus.mem_busy = 1'b0;
      end
    end
  end

  // Transmitter: goes busy for a few cycles after each start pulse.
  initial begin : transmitter
    forever begin
      @(posedge clk); #1;
      if (bus.txgo) begin
        bus.txready = 1'b0;
        repeat ($urandom_range(2, 6)) @(posedge clk);
        #1 bus.txready = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic clear_obs();
    q_txn.delete(); q_tx.delete(); n_ovr = 0; n_viol = 0; n_active = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    repeat ($urandom_range(0, 3)) @(posedge clk);
    @(posedge clk); #1;
    bus.rxdata = b; bus.rxint = 1'b1;
    @(posedge clk); #1;
    bus.rxint = 1'b0;
  endtask

  task automatic send_cmd(input bit w, input logic [31:0] a, input logic [31:0] d);
    send_byte(w ? 8'h57 : 8'h52);
    for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8]);
    if (w) for (int i = 3; i >= 0; i--) send_byte(d[i*8 +: 8]);
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (!bus.active) begin ok = 1'b1; break; end
    end
  endtask

  function automatic logic [31:0] tx_word();
    logic [31:0] g = 32'h0;
    foreach (q_tx[i]) g = {g[23:0], q_tx[i]};
    return g;
  endfunction

  // One full command with checks of the bus access and the response bytes.
  task automatic do_cmd(input string nm, input bit w, input logic [31:0] a, input logic [31:0] d);
    bit ok;
    logic [31:0] exp_resp;
    txn_t got;
    exp_resp = model_resp(w, a);
    if (w) model_mem[a] = d;
    clear_obs();
    send_cmd(w, a, d);
    wait_idle(ok);
    repeat (2) @(posedge clk);
    got = (q_txn.size() > 0) ? q_txn[0] : '0;
    n_checks++; if (!ok || q_txn.size() != 1) $display("FAIL %s_txn_count: got %0d idle=%0b, want 1", nm, q_txn.size(), ok); else n_pass++;
    n_checks++; if ({got.we, got.addr} !== {w, a}) $display("FAIL %s_access: got we=%0b addr=%h, want we=%0b addr=%h", nm, got.we, got.addr, w, a); else n_pass++;
    if (w) begin
      n_checks++; if (got.data !== d) $display("FAIL %s_wdata: got %h, want %h", nm, got.data, d); else n_pass++;
    end
    n_checks++; if (q_tx.size() != (w ? 1 : 4) || tx_word() !== exp_resp) $display("FAIL %s_response: got %0d bytes %h, want %h", nm, q_tx.size(), tx_word(), exp_resp); else n_pass++;
    n_checks++; if (n_viol != 0) $display("FAIL %s_protocol: got %0d violations, want 0", nm, n_viol); else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk); #1;
    n_checks++; if (outs !== 77'h0) $display("FAIL reset_outputs: got %h, want 0", outs); else n_pass++;
    reset = 1'b1;
  endtask

  task automatic test_write();
    do_cmd("write", 1'b1, 32'hF000_00C0, 32'h0000_0041);
    n_checks++; if (bus.active !== 1'b0 || bus.mem_addr !== 32'hF000_00C0) $display("FAIL write_hold: got active=%0b addr=%h, want 0 F00000C0", bus.active, bus.mem_addr); else n_pass++;
  endtask

  task automatic test_read();
    model_mem[32'h1234_5678] = 32'hDEAD_BEEF;
    slave_mem[32'h1234_5678] = 32'hDEAD_BEEF;
    do_cmd("read", 1'b0, 32'h1234_5678, 32'h0);
  endtask

  task automatic test_junk();
    clear_obs();
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h41);
    repeat (10) @(posedge clk);
    n_checks++; if (q_txn.size() + q_tx.size() + n_active != 0) $display("FAIL junk_ignored: got txn=%0d tx=%0d active=%0d, want 0", q_txn.size(), q_tx.size(), n_active); else n_pass++;
    do_cmd("junk_then_read", 1'b0, 32'($urandom), 32'h0);
  endtask

  task automatic test_timeout();
    clear_obs();
    send_byte(8'h57); send_byte(8'h01); send_byte(8'h02);
    repeat (60) @(posedge clk); #1;
    n_checks++; if (bus.active !== 1'b0 || q_txn.size() != 0 || q_tx.size() != 0) $display("FAIL timeout_abort: got active=%0b txn=%0d tx=%0d, want 0", bus.active, q_txn.size(), q_tx.size()); else n_pass++;
    do_cmd("after_timeout", 1'b0, 32'h0000_0004, 32'h0);
  endtask

  task automatic test_overrun();
    bit ok;
    logic [31:0] a, exp_resp;
    a = 32'h2000_0000 | 32'($urandom_range(0, 255));
    exp_resp = model_resp(1'b0, a);
    clear_obs();
    hold_busy = 1'b1;
    send_cmd(1'b0, a, 32'h0);
    for (int i = 0; i < 100 && q_txn.size() == 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    send_byte(8'h52);
    repeat (2) @(posedge clk); #1;
    n_checks++; if (n_ovr != 1) $display("FAIL overrun_pulse: got %0d pulses, want 1", n_ovr); else n_pass++;
    n_checks++; if (bus.active !== 1'b1 || q_tx.size() != 0) $display("FAIL overrun_state: got active=%0b tx=%0d, want 1 0", bus.active, q_tx.size()); else n_pass++;
    hold_busy = 1'b0;
    wait_idle(ok);
    n_checks++; if (!ok || q_txn.size() != 1 || tx_word() !== exp_resp) $display("FAIL overrun_resp: got txn=%0d resp=%h, want 1 %h", q_txn.size(), tx_word(), exp_resp); else n_pass++;
  endtask

  task automatic test_reset_mid(input bit in_tx);
    logic [31:0] a;
    bit seen = 1'b0;
    a = 32'h3000_0010;
    clear_obs();
    send_cmd(!in_tx, a, 32'hCAFE_0001);
    for (int i = 0; i < 300 && !seen; i++) begin
      @(posedge clk); #1;
      seen = in_tx ? bus.txgo : (bus.mem_writeEnable || bus.mem_readEnable);
    end
    reset = 1'b0;
    #1;
    n_checks++; if (!seen || outs !== 77'h0) $display("FAIL reset_mid_%0d: got seen=%0b outs=%h, want 1 0", in_tx, seen, outs); else n_pass++;
    repeat (2) @(posedge clk); #1;
    reset = 1'b1;
    repeat (12) @(posedge clk);
    do_cmd(in_tx ? "post_reset_tx" : "post_reset_strobe", 1'b1, a, 32'($urandom));
  endtask

  task automatic test_random();
    for (int k = 0; k < 16; k++) begin
      do_cmd("random", 1'($urandom), 32'h1000_0000 + 32'($urandom_range(0, 3)) * 4, 32'($urandom));
    end
  endtask

  initial begin
    bus.rxdata = 8'h00; bus.rxint = 1'b0; bus.txready = 1'b1;
    bus.mem_read = 32'h0; bus.mem_busy = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_junk();
    test_timeout();
    test_overrun();
    test_reset_mid(1'b0);
    test_reset_mid(1'b1);
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
